seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor that adds CHUNK bits per clock with a registered carry between chunks.
- Generalises the team's fixed 8-bit ripple-carry adder to WIDTH bits, adds subtract mode, carry-in, signed overflow and a start/busy/done handshake.
- Feeds the radix-4 multiplier datapath where a short carry chain per cycle matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on the accepted start edge
- b  input  WIDTH  operand B, captured on the accepted start edge
- cin  input  1  carry-in for add; ignored when sub=1
- sub  input  1  1: compute a-b; 0: compute a+b+cin; captured with the operands
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result registers update
- sum  output  WIDTH  result; holds its value between operations
- cout  output  1  carry out of the MSB (for sub, 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; busy, done, sum, cout and ovf all 0; internal operand, carry and chunk-counter registers cleared. No done pulse follows an aborted operation.
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- IDLE:
  - done=0 except in the cycle right after completion.
  - start=1 at an edge: latch a, bb and c0 into shift registers, clear the counter, go to RUN, busy=1.
- RUN, on each edge:
  - Add the low CHUNK bits of A and B with the carry register.
  - Shift the CHUNK-bit result into the top of the partial-sum register.
  - Carry register takes the chunk carry-out; shift A and B right by CHUNK; increment the counter.
- Completion, on the NCHUNK-th RUN edge:
  - sum = final partial sum; cout = final carry.
  - ovf = (A[MSB] == bb[MSB]) && (sum[MSB] != A[MSB]), using the captured values.
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle after the NCHUNK-th edge following the accepted start edge. With defaults that is 4 clocks. Throughput: one operation per NCHUNK cycles.
- Back-to-back operation: start=1 while done=1 is accepted (busy is already 0). The new operation begins, and sum keeps the old result until the new completion.
- start while busy=1 is ignored. Changes to a, b, cin or sub after capture have no effect.
- sum, cout and ovf change only at completion or reset.
- Arithmetic is modulo 2^WIDTH; cout and ovf carry the overflow information.
- CHUNK == WIDTH is legal: single-cycle RUN, latency 1.

Optional Feature:
- SEQ_CHUNK_ADDER_ACCUM_EN defined:
  - Adds input port acc (1 bit).
  - When start is accepted with acc=1, operand A is the current sum register instead of port a. This gives running accumulation: sum = sum ± b.
  - acc=0 behaves exactly as in the base block.
- Macro undefined: port acc does not exist; A is always port a.

Test Plan (WIDTH=16, CHUNK=4):
- Add: start with a=0x1234, b=0x4321, cin=0, sub=0 -> done pulses exactly 4 cycles after the start edge, for one cycle; sum=0x5555, cout=0, ovf=0; busy high for the 4 cycles.
- Full carry propagation and carry-in: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFE, b=0x0000, cin=1 -> sum=0x7FFF, ovf=0.
- Signed overflow and subtract:
  - a=0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
  - sub a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - sub a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Handshake:
  - start pulsed mid-operation with different operands -> ignored, first result intact.
  - start held high across done -> second operation starts back-to-back, second done exactly 4 cycles later.
- Reset mid-operation: assert rst 2 cycles into RUN -> busy, done, sum, cout and ovf go to 0 immediately (asynchronously); no done pulse afterwards. A following add of 0x0003+0x0004 gives sum=0x0007.
- With SEQ_CHUNK_ADDER_ACCUM_EN: sum=0x0010, then start acc=1 with b=0x0005 -> sum=0x0015; repeat with sub=1, b=0x0015 -> sum=0x0000, cout=1.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered inter-chunk carry.
// Optional feature macro SEQ_CHUNK_ADDER_ACCUM_EN adds port acc (A taken from the sum register).
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef SEQ_CHUNK_ADDER_ACCUM_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             bb_msb;

  logic [WIDTH-1:0] a_src;
  logic [WIDTH-1:0] bb_in;
  logic             c0_in;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] psum_nxt;
  logic             last;

  // Operand selection and the per-cycle chunk adder.
  always_comb begin
    a_src = a;
`ifdef SEQ_CHUNK_ADDER_ACCUM_EN
    if (acc) a_src = sum;
`endif
    bb_in    = sub ? ~b : b;
    c0_in    = sub | cin;
    csum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(c_q);
    psum_nxt = (psum >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
    last     = (cnt == CW'(NCHUNK - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      psum   <= '0;
      c_q    <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      bb_msb <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a_src;
            b_q    <= bb_in;
            c_q    <= c0_in;
            a_msb  <= a_src[WIDTH-1];
            bb_msb <= bb_in[WIDTH-1];
            psum   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_q  <= a_q >> CHUNK;
          b_q  <= b_q >> CHUNK;
          c_q  <= csum[CHUNK];
          psum <= psum_nxt;
          cnt  <= cnt + CW'(1);
          // Final chunk: publish result and flags together with the done pulse.
          if (last) begin
            sum   <= psum_nxt;
            cout  <= csum[CHUNK];
            ovf   <= (a_msb == bb_msb) && (psum_nxt[WIDTH-1] != a_msb);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: directed corner cases plus randomized operations.
module tb_seq_chunk_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned NCH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
`ifdef SEQ_CHUNK_ADDER_ACCUM_EN
  logic         acc;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
`ifdef SEQ_CHUNK_ADDER_ACCUM_EN
    .acc   (acc),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          vecs = 0;
  int          errs = 0;
  int          cyc  = 0;
  logic [15:0] model_sum;
  logic [15:0] hold_sum;
  logic        hold_cout;
  logic        hold_ovf;
  logic        prev_done;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endfunction

  // Arithmetic reference: plain integer math on the mathematical operands.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
    exp_t   e;
    int     sa;
    int     sbv;
    int     r;
    longint u;
    sa  = int'($signed(av));
    sbv = int'($signed(bv));
    if (sb) begin
      r      = sa - sbv;
      e.sum  = 16'(av - bv);
      e.cout = (av >= bv);
    end else begin
      u      = longint'(av) + longint'(bv) + longint'(ci);
      r      = sa + sbv + int'(ci);
      e.sum  = u[15:0];
      e.cout = u[16];
    end
    e.ovf = (r > 32767) || (r < -32768);
    e.cyc = 0;
    return e;
  endfunction

  // Drive a start at the current falling edge; it is accepted at the next rising edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb, input logic ac);
    exp_t        e;
    logic [15:0] aeff;
    aeff  = av;
    a     = av;
    b     = bv;
    cin   = ci;
    sub   = sb;
`ifdef SEQ_CHUNK_ADDER_ACCUM_EN
    acc   = ac;
    if (ac) aeff = model_sum;
`else
    if (ac) aeff = av;
`endif
    start = 1'b1;
    e     = model(aeff, bv, ci, sb);
    e.cyc = cyc + 1 + int'(NCH);
    sbq.push_back(e);
    model_sum = e.sum;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb, input logic ac);
    wait_idle();
    issue(av, bv, ci, sb, ac);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // start held high across done: second op must be taken back-to-back.
  task automatic b2b(input logic [15:0] a1, input logic [15:0] b1, input logic s1,
                     input logic [15:0] a2, input logic [15:0] b2, input logic s2, input logic ac2);
    bit found;
    found = 1'b0;
    wait_idle();
    issue(a1, b1, 1'b0, s1, 1'b0);
    @(negedge clk);
    a   = a2;
    b   = b2;
    sub = s2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        issue(a2, b2, 1'b0, s2, ac2);
        found = 1'b1;
        break;
      end
    end
    if (!found) check("b2b_timeout", 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom());
    endcase
  endfunction

  // Monitor: pops an expectation on every done and checks hold behaviour otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      hold_sum  = '0;
      hold_cout = 1'b0;
      hold_ovf  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_one_cycle", 32'(prev_done), 32'd0);
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("sum", 32'(sum), 32'(e.sum));
          check("cout", 32'(cout), 32'(e.cout));
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("latency", 32'(cyc), 32'(e.cyc));
          hold_sum  = e.sum;
          hold_cout = e.cout;
          hold_ovf  = e.ovf;
        end
      end else begin
        check("hold", {14'd0, sum, cout, ovf}, {14'd0, hold_sum, hold_cout, hold_ovf});
      end
      prev_done = done;
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
`ifdef SEQ_CHUNK_ADDER_ACCUM_EN
    acc       = 1'b0;
`endif
    model_sum = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {13'd0, busy, done, sum, cout, ovf}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h7FFE, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);

    // Start pulsed while busy must be ignored.
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    a     = 16'hAAAA;
    b     = 16'h5555;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    b2b(16'h0100, 16'h0023, 1'b0, 16'h9000, 16'h9000, 1'b0, 1'b0);

    // Asynchronous reset two RUN edges into an operation.
    wait_idle();
    issue(16'h5678, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {13'd0, busy, done, sum, cout, ovf}, 32'd0);
    sbq.delete();
    model_sum = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_CHUNK_ADDER_ACCUM_EN
    do_op(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_op(16'hBEEF, 16'h0005, 1'b0, 1'b0, 1'b1);
    do_op(16'hBEEF, 16'h0015, 1'b0, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      logic ac;
      ac = 1'b0;
`ifdef SEQ_CHUNK_ADDER_ACCUM_EN
      ac = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 3) == 3)
        b2b(pick(), pick(), 1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)), ac);
      else
        do_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ac);
    end

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
